// File: rtl/tsense_reader.sv
// tsense_reader: captures SAR bias results {ib, ibf} into a FIFO and streams them out as UART-style frames.
// Define TSENSE_READER_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module tsense_reader #(
  parameter int CLKS_PER_BIT = 10,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          valid,
  input  logic [7:0]                    ib,
  input  logic [7:0]                    ibf,
  input  logic                          ovf_clr,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0]    BIT_RELOAD = 8'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

`ifdef TSENSE_READER_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [15:0] word);
    even_parity = ^word;
  endfunction
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
`endif

  logic               valid_r;
  logic               armed_r;
  logic [15:0]        mem_r [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [LW-1:0]      level_r;
  logic               ovf_r;
  state_t             state_r;
  logic [7:0]         bit_cnt_r;
  logic [3:0]         bit_idx_r;
  logic [15:0]        shift_r;
  logic               tx_r;
  logic               busy_r;
`ifdef TSENSE_READER_PARITY_EN
  logic               parity_r;
`endif

  logic               capture_s;
  logic               full_s;
  logic               pop_s;
  logic               push_s;
  logic               drop_s;
  logic [15:0]        head_s;

  // FIFO handshake decode: edge-detected capture, pop on IDLE exit, drop only when full without a pop
  always_comb begin
    capture_s = valid & ~valid_r & armed_r;
    full_s    = (level_r == FULL_LEVEL);
    pop_s     = (state_r == ST_IDLE) && (level_r != {LW{1'b0}});
    push_s    = capture_s && (!full_s || pop_s);
    drop_s    = capture_s && full_s && !pop_s;
    head_s    = mem_r[rd_ptr_r];
  end

  // valid edge detector; armed_r blocks capture until valid has been seen low after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      valid_r <= valid;
      armed_r <= armed_r | ~valid;
    end
  end

  // FIFO storage array
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {ib, ibf};
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1'b1);
        2'b01:   level_r <= level_r - LW'(1'b1);
        default: level_r <= level_r;
      endcase
      // an overflow in the same cycle as a clear keeps the flag set
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  // Transmitter FSM; every bit period is a down-count from BIT_RELOAD to zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 8'd0;
      bit_idx_r <= 4'd0;
      shift_r   <= 16'd0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
`ifdef TSENSE_READER_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            shift_r   <= head_s;
`ifdef TSENSE_READER_PARITY_EN
            parity_r  <= even_parity(head_s);
`endif
            state_r   <= ST_START;
            tx_r      <= 1'b0;
            busy_r    <= 1'b1;
            bit_cnt_r <= BIT_RELOAD;
          end
        end
        ST_START: begin
          if (bit_cnt_r == 8'd0) begin
            state_r   <= ST_DATA;
            tx_r      <= shift_r[0];
            shift_r   <= {1'b0, shift_r[15:1]};
            bit_idx_r <= 4'd0;
            bit_cnt_r <= BIT_RELOAD;
          end else begin
            bit_cnt_r <= bit_cnt_r - 8'd1;
          end
        end
        ST_DATA: begin
          if (bit_cnt_r == 8'd0) begin
            bit_cnt_r <= BIT_RELOAD;
            if (bit_idx_r == 4'd15) begin
`ifdef TSENSE_READER_PARITY_EN
              state_r <= ST_PARITY;
              tx_r    <= parity_r;
`else
              state_r <= ST_STOP;
              tx_r    <= 1'b1;
`endif
            end else begin
              bit_idx_r <= bit_idx_r + 4'd1;
              tx_r      <= shift_r[0];
              shift_r   <= {1'b0, shift_r[15:1]};
            end
          end else begin
            bit_cnt_r <= bit_cnt_r - 8'd1;
          end
        end
`ifdef TSENSE_READER_PARITY_EN
        ST_PARITY: begin
          if (bit_cnt_r == 8'd0) begin
            state_r   <= ST_STOP;
            tx_r      <= 1'b1;
            bit_cnt_r <= BIT_RELOAD;
          end else begin
            bit_cnt_r <= bit_cnt_r - 8'd1;
          end
        end
`endif
        ST_STOP: begin
          // returning to IDLE guarantees at least one idle cycle before the next START
          if (bit_cnt_r == 8'd0) begin
            state_r <= ST_IDLE;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            bit_cnt_r <= bit_cnt_r - 8'd1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          tx_r      <= 1'b1;
          busy_r    <= 1'b0;
          bit_cnt_r <= 8'd0;
        end
      endcase
    end
  end

  assign tx         = tx_r;
  assign tx_busy    = busy_r;
  assign fifo_level = level_r;
  assign ovf        = ovf_r;

endmodule

// File: tb/tb_tsense_reader.sv
// Scoreboard bench for tsense_reader: stimulus pushes expected words, a serial monitor decodes tx frames and compares.
`timescale 1ns/1ps
module tb_tsense_reader;

  localparam int CPB   = 10;
  localparam int DEPTH = 4;
  localparam int LW    = 3;
`ifdef TSENSE_READER_PARITY_EN
  localparam int FRAME_BITS = 19;
`else
  localparam int FRAME_BITS = 18;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          valid = 1'b0;
  logic [7:0]    ib = 8'h00;
  logic [7:0]    ibf = 8'h00;
  logic          ovf_clr = 1'b0;
  logic          tx;
  logic          tx_busy;
  logic [LW-1:0] fifo_level;
  logic          ovf;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int frames_seen = 0;
  int prev_start = 0;
  int last_start = 0;
  logic [15:0] sb_q[$];

  tsense_reader #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .valid(valid), .ib(ib), .ibf(ibf),
    .ovf_clr(ovf_clr), .tx(tx), .tx_busy(tx_busy), .fifo_level(fifo_level), .ovf(ovf)
  );

  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // returns #1 after the rising edge that brings cyc to n
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] w, input int at, input int hold, input bit expect_it);
    goto(at);
    ib = w[15:8];
    ibf = w[7:0];
    valid = 1'b1;
    if (expect_it) sb_q.push_back(w);
    goto(at + hold);
    valid = 1'b0;
  endtask

  // serial monitor: decodes each frame at mid-bit and checks it against the scoreboard head
  initial begin
    logic [19:0] bits;
    logic [15:0] exp_w;
    bit have_exp, aborted, busy_ok;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && tx === 1'b0) begin
        prev_start = last_start;
        last_start = cyc;
        bits = 20'd0;
        aborted = 1'b0;
        busy_ok = 1'b1;
        have_exp = (sb_q.size() != 0);
        exp_w = have_exp ? sb_q.pop_front() : 16'h0000;
        for (int off = 0; off <= FRAME_CYC; off++) begin
          if (off > 0) @(negedge clk);
          if (reset_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (off < FRAME_CYC) begin
            if (tx_busy !== 1'b1) busy_ok = 1'b0;
            if (off % CPB == CPB / 2) bits[off / CPB] = tx;
          end else if (tx_busy !== 1'b0 || tx !== 1'b1) begin
            busy_ok = 1'b0;
          end
        end
        if (!aborted) begin
          frames_seen++;
          check("frame_expected", 32'(have_exp), 32'd1);
          check("frame_word", 32'(bits[16:1]), 32'(exp_w));
          check("start_bit", 32'(bits[0]), 32'd0);
          check("stop_bit", 32'(bits[FRAME_BITS-1]), 32'd1);
`ifdef TSENSE_READER_PARITY_EN
          check("parity_bit", 32'(bits[17]), 32'(^exp_w));
`endif
          check("busy_window", 32'(busy_ok), 32'd1);
        end
      end
    end
  end

  initial begin
    #(100 * 20000);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, f0;
    // reset state
    goto(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    reset_n = 1'b1;
    goto(6);

    // single result, level 1 then 0 once the transmitter pops it
    c = cyc;
    ib = 8'hA5; ibf = 8'h3C; valid = 1'b1; sb_q.push_back(16'hA53C);
    goto(c + 1);
    check("single_level1", 32'(fifo_level), 32'd1);
    goto(c + 2);
    check("single_level0", 32'(fifo_level), 32'd0);
    check("single_busy", 32'(tx_busy), 32'd1);
    goto(c + 3);
    valid = 1'b0;
    goto(c + FRAME_CYC + 20);

    // held-high valid produces exactly one frame
    c = cyc; f0 = frames_seen;
    send(16'h1234, c, 50, 1'b1);
    goto(c + FRAME_CYC + 70);
    check("held_valid_frames", 32'(frames_seen - f0), 32'd1);

    // back-to-back buffered words, parity vectors 0001/0003
    c = cyc;
    send(16'h0001, c, 2, 1'b1);
    send(16'h0003, c + 5, 2, 1'b1);
    goto(c + 2 * FRAME_CYC + 30);
    check("b2b_gap", 32'(last_start - prev_start), 32'(FRAME_CYC + 1));

    // overflow: first word in flight, four buffered, sixth dropped
    c = cyc;
    send(16'h1111, c, 3, 1'b1);
    send(16'h2222, c + 20, 3, 1'b1);
    send(16'h3333, c + 40, 3, 1'b1);
    send(16'h4444, c + 60, 3, 1'b1);
    send(16'h5555, c + 80, 3, 1'b1);
    goto(c + 95);
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_no_ovf", 32'(ovf), 32'd0);
    send(16'h6666, c + 100, 2, 1'b0);
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_level", 32'(fifo_level), 32'd4);
    goto(c + 120);
    ib = 8'h77; ibf = 8'h77; valid = 1'b1; ovf_clr = 1'b1;
    goto(c + 121);
    ovf_clr = 1'b0;
    check("ovf_clr_vs_drop", 32'(ovf), 32'd1);
    goto(c + 123);
    valid = 1'b0;
    goto(c + 130);
    ovf_clr = 1'b1;
    goto(c + 131);
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);
    // push while full on the same edge as the transmitter pop
    goto(c + FRAME_CYC + 2);
    ib = 8'h88; ibf = 8'h88; valid = 1'b1; sb_q.push_back(16'h8888);
    goto(c + FRAME_CYC + 3);
    check("push_pop_full_level", 32'(fifo_level), 32'd4);
    check("push_pop_full_ovf", 32'(ovf), 32'd0);
    goto(c + FRAME_CYC + 5);
    valid = 1'b0;
    goto(c + 6 * (FRAME_CYC + 1) + 30);
    check("overflow_drain", 32'(sb_q.size()), 32'd0);

    // reset 90 cycles into a frame with a second word buffered
    c = cyc;
    send(16'h5A5A, c, 2, 1'b1);
    send(16'h0F0F, c + 5, 2, 1'b0);
    goto(c + 92);
    f0 = frames_seen;
    reset_n = 1'b0;
    ib = 8'h77; ibf = 8'h88; valid = 1'b1;
    #1;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(tx_busy), 32'd0);
    check("abort_level", 32'(fifo_level), 32'd0);
    goto(c + 100);
    reset_n = 1'b1;
    goto(c + 130);
    check("held_at_reset_level", 32'(fifo_level), 32'd0);
    check("held_at_reset_busy", 32'(tx_busy), 32'd0);
    valid = 1'b0;
    goto(c + 300);
    check("abort_no_frames", 32'(frames_seen - f0), 32'd0);
    check("abort_queue", 32'(sb_q.size()), 32'd0);

    // a fresh low-to-high valid after reset captures again
    send(16'h7788, c + 300, 3, 1'b1);
    goto(c + 300 + FRAME_CYC + 30);
    check("post_reset_frames", 32'(frames_seen - f0), 32'd1);
    check("final_queue", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
